sdram_arbit: RTL and testbench

Command arbiter between the SDRAM sub-controllers (init, auto-refresh, write, read) and the SDRAM device pins. It consumes the `sdram_wr_req`/`sdram_rd_req` requests produced by the FIFO control stage and the refresh requests from the refresh timer. It grants exactly one sub-controller at a time and muxes that controller's command, bank, address and write data onto the device bus. Priority is fixed: auto-refresh > write > read.

---
 rtl/sdram_pkg.sv | 24 ++
 rtl/sdram_arbit.sv | 173 +++++++++++++++++
 tb/tb_sdram_arbit.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/sdram_pkg.sv
// Shared SDRAM definitions: command encodings {cs_n,ras_n,cas_n,we_n},
// the NOP bank/address, and the one-hot arbiter state encoding.
package sdram_pkg;

  localparam logic [3:0]  CMD_NOP       = 4'b0111;
  localparam logic [3:0]  CMD_PRECHARGE = 4'b0010;
  localparam logic [3:0]  CMD_AREF      = 4'b0001;
  localparam logic [3:0]  CMD_ACTIVE    = 4'b0011;
  localparam logic [3:0]  CMD_WRITE     = 4'b0100;
  localparam logic [3:0]  CMD_READ      = 4'b0101;
  localparam logic [3:0]  CMD_MODE_REG  = 4'b0000;

  localparam logic [1:0]  NOP_BA   = 2'b11;
  localparam logic [12:0] NOP_ADDR = 13'h1FFF;

  typedef enum logic [4:0] {
    ST_IDLE  = 5'b00001,
    ST_ARBIT = 5'b00010,
    ST_AREF  = 5'b00100,
    ST_WRITE = 5'b01000,
    ST_READ  = 5'b10000
  } arb_state_e;

endpackage

// File: rtl/sdram_arbit.sv
// Fixed-priority command arbiter (refresh > write > read) between the SDRAM
// sub-controllers and the device pins; one grant at a time, no preemption.
//
// state | meaning
// IDLE  | waiting for init to finish; init bus on the pins
// ARBIT | no grant; NOP on the pins, requests sampled here only
// AREF  | auto-refresh granted
// WRITE | write granted; DQ driven when wr_sdram_en
// READ  | read granted
module sdram_arbit
  import sdram_pkg::*;
(
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        init_end,
  input  logic [3:0]  init_cmd,
  input  logic [1:0]  init_ba,
  input  logic [12:0] init_addr,
  input  logic        aref_req,
  input  logic        aref_end,
  input  logic [3:0]  aref_cmd,
  input  logic [1:0]  aref_ba,
  input  logic [12:0] aref_addr,
  input  logic        wr_req,
  input  logic        wr_end,
  input  logic [3:0]  wr_cmd,
  input  logic [1:0]  wr_ba,
  input  logic [12:0] wr_addr,
  input  logic        wr_sdram_en,
  input  logic [15:0] wr_sdram_data,
  input  logic        rd_req,
  input  logic        rd_end,
  input  logic [3:0]  rd_cmd,
  input  logic [1:0]  rd_ba,
  input  logic [12:0] rd_addr,
  output logic        aref_en,
  output logic        wr_en,
  output logic        rd_en,
  output logic        sdram_cke,
  output logic        sdram_cs_n,
  output logic        sdram_ras_n,
  output logic        sdram_cas_n,
  output logic        sdram_we_n,
  output logic [1:0]  sdram_ba,
  output logic [12:0] sdram_addr,
  inout  wire  [15:0] sdram_dq
);

  arb_state_e  r_state;
  arb_state_e  w_state_nxt;
  logic        r_aref_en;
  logic        r_wr_en;
  logic        r_rd_en;
  logic        w_aref_en_nxt;
  logic        w_wr_en_nxt;
  logic        w_rd_en_nxt;
  logic [3:0]  w_cmd;
  logic [1:0]  w_ba;
  logic [12:0] w_addr;
  logic        w_dq_oe;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state   <= ST_IDLE;
      r_aref_en <= 1'b0;
      r_wr_en   <= 1'b0;
      r_rd_en   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_aref_en <= w_aref_en_nxt;
      r_wr_en   <= w_wr_en_nxt;
      r_rd_en   <= w_rd_en_nxt;
    end
  end

  // Grants are registered alongside the state so each one tracks its state exactly.
  always_comb begin
    w_state_nxt   = r_state;
    w_aref_en_nxt = r_aref_en;
    w_wr_en_nxt   = r_wr_en;
    w_rd_en_nxt   = r_rd_en;
    unique case (r_state)
      ST_IDLE: begin
        if (init_end) w_state_nxt = ST_ARBIT;
      end
      ST_ARBIT: begin
        if (aref_req) begin
          w_state_nxt   = ST_AREF;
          w_aref_en_nxt = 1'b1;
        end else if (wr_req) begin
          w_state_nxt = ST_WRITE;
          w_wr_en_nxt = 1'b1;
        end else if (rd_req) begin
          w_state_nxt = ST_READ;
          w_rd_en_nxt = 1'b1;
        end
      end
      ST_AREF: begin
        if (aref_end) begin
          w_state_nxt   = ST_ARBIT;
          w_aref_en_nxt = 1'b0;
        end
      end
      ST_WRITE: begin
        if (wr_end) begin
          w_state_nxt = ST_ARBIT;
          w_wr_en_nxt = 1'b0;
        end
      end
      ST_READ: begin
        if (rd_end) begin
          w_state_nxt = ST_ARBIT;
          w_rd_en_nxt = 1'b0;
        end
      end
      default: begin
        w_state_nxt   = ST_IDLE;
        w_aref_en_nxt = 1'b0;
        w_wr_en_nxt   = 1'b0;
        w_rd_en_nxt   = 1'b0;
      end
    endcase
  end

  always_comb begin
    w_cmd  = init_cmd;
    w_ba   = init_ba;
    w_addr = init_addr;
    unique case (r_state)
      ST_ARBIT: begin
        w_cmd  = CMD_NOP;
        w_ba   = NOP_BA;
        w_addr = NOP_ADDR;
      end
      ST_AREF: begin
        w_cmd  = aref_cmd;
        w_ba   = aref_ba;
        w_addr = aref_addr;
      end
      ST_WRITE: begin
        w_cmd  = wr_cmd;
        w_ba   = wr_ba;
        w_addr = wr_addr;
      end
      ST_READ: begin
        w_cmd  = rd_cmd;
        w_ba   = rd_ba;
        w_addr = rd_addr;
      end
      default: begin
        w_cmd  = init_cmd;
        w_ba   = init_ba;
        w_addr = init_addr;
      end
    endcase
  end

  // DQ is only ever driven inside a write grant, so reset releases it at once.
  assign w_dq_oe = wr_sdram_en && (r_state == ST_WRITE);
  assign sdram_dq = w_dq_oe ? wr_sdram_data : 16'hzzzz;

  assign aref_en     = r_aref_en;
  assign wr_en       = r_wr_en;
  assign rd_en       = r_rd_en;
  assign sdram_cke   = 1'b1;
  assign sdram_cs_n  = w_cmd[3];
  assign sdram_ras_n = w_cmd[2];
  assign sdram_cas_n = w_cmd[1];
  assign sdram_we_n  = w_cmd[0];
  assign sdram_ba    = w_ba;
  assign sdram_addr  = w_addr;

endmodule

// File: tb/tb_sdram_arbit.sv
// Scoreboard bench for sdram_arbit: expected grants/pins/DQ are queued as
// stimulus is driven and compared one edge later.
module tb_sdram_arbit;
  import sdram_pkg::*;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic        init_end;
  logic        aref_req, aref_end, wr_req, wr_end, rd_req, rd_end;
  logic        wr_sdram_en;
  logic [15:0] wr_sdram_data;
  logic        aref_en, wr_en, rd_en, sdram_cke;
  logic        sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n;
  logic [1:0]  sdram_ba;
  logic [12:0] sdram_addr;
  wire  [15:0] sdram_dq;
  logic        tb_dq_en;

  localparam logic [15:0] TB_DQ = 16'h0F0F;

  localparam logic [3:0]  INIT_CMD = CMD_PRECHARGE;
  localparam logic [1:0]  INIT_BA  = 2'b00;
  localparam logic [12:0] INIT_ADDR = 13'h0400;
  localparam logic [3:0]  AREF_CMD = CMD_AREF;
  localparam logic [1:0]  AREF_BA  = 2'b01;
  localparam logic [12:0] AREF_ADDR = 13'h0AAA;
  localparam logic [3:0]  WR_CMD = CMD_WRITE;
  localparam logic [1:0]  WR_BA  = 2'b10;
  localparam logic [12:0] WR_ADDR = 13'h0123;
  localparam logic [3:0]  RD_CMD = CMD_READ;
  localparam logic [1:0]  RD_BA  = 2'b00;
  localparam logic [12:0] RD_ADDR = 13'h0456;

  // A weak stand-in for the device: visible on DQ only when the arbiter releases it.
  assign sdram_dq = tb_dq_en ? TB_DQ : 16'hzzzz;

  always #5 sys_clk = ~sys_clk;

  sdram_arbit dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .init_end(init_end),
    .init_cmd(INIT_CMD), .init_ba(INIT_BA), .init_addr(INIT_ADDR),
    .aref_req(aref_req), .aref_end(aref_end),
    .aref_cmd(AREF_CMD), .aref_ba(AREF_BA), .aref_addr(AREF_ADDR),
    .wr_req(wr_req), .wr_end(wr_end),
    .wr_cmd(WR_CMD), .wr_ba(WR_BA), .wr_addr(WR_ADDR),
    .wr_sdram_en(wr_sdram_en), .wr_sdram_data(wr_sdram_data),
    .rd_req(rd_req), .rd_end(rd_end),
    .rd_cmd(RD_CMD), .rd_ba(RD_BA), .rd_addr(RD_ADDR),
    .aref_en(aref_en), .wr_en(wr_en), .rd_en(rd_en), .sdram_cke(sdram_cke),
    .sdram_cs_n(sdram_cs_n), .sdram_ras_n(sdram_ras_n),
    .sdram_cas_n(sdram_cas_n), .sdram_we_n(sdram_we_n),
    .sdram_ba(sdram_ba), .sdram_addr(sdram_addr), .sdram_dq(sdram_dq)
  );

  typedef struct {
    string       tag;
    bit          is_dq;
    logic [31:0] exp;
  } sb_item_t;

  sb_item_t sb[$];
  int checks   = 0;
  int failures = 0;

  function automatic logic [31:0] pk(logic [2:0] en, logic [3:0] c, logic [1:0] b, logic [12:0] a);
    return {10'd0, en, c, b, a};
  endfunction

  logic [31:0] e_init, e_nop, e_aref, e_wr, e_rd;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input logic [31:0] exp_pins, input bit dq_chk, input logic [15:0] exp_dq);
    sb_item_t it;
    it.tag = tag; it.is_dq = 1'b0; it.exp = exp_pins;
    sb.push_back(it);
    if (dq_chk) begin
      it.tag = {tag, "_dq"}; it.is_dq = 1'b1; it.exp = {16'd0, exp_dq};
      sb.push_back(it);
    end
  endtask

  task automatic drain();
    sb_item_t it;
    logic [31:0] obs;
    while (sb.size() > 0) begin
      it = sb.pop_front();
      if (it.is_dq) obs = {16'd0, sdram_dq};
      else obs = pk({aref_en, wr_en, rd_en},
                    {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n},
                    sdram_ba, sdram_addr);
      check_val(it.tag, obs, it.exp);
    end
  endtask

  // Inputs change at negedge; the state after the next posedge is compared.
  task automatic cyc(input string tag, input logic [31:0] exp_pins, input bit dq_chk, input logic [15:0] exp_dq);
    push(tag, exp_pins, dq_chk, exp_dq);
    @(posedge sys_clk);
    #1;
    drain();
    @(negedge sys_clk);
  endtask

  initial begin
    e_init = pk(3'b000, INIT_CMD, INIT_BA, INIT_ADDR);
    e_nop  = pk(3'b000, CMD_NOP, NOP_BA, NOP_ADDR);
    e_aref = pk(3'b100, AREF_CMD, AREF_BA, AREF_ADDR);
    e_wr   = pk(3'b010, WR_CMD, WR_BA, WR_ADDR);
    e_rd   = pk(3'b001, RD_CMD, RD_BA, RD_ADDR);

    sys_rst_n = 1'b0; init_end = 1'b0;
    aref_req = 0; aref_end = 0; wr_req = 0; wr_end = 0; rd_req = 0; rd_end = 0;
    wr_sdram_en = 1'b0; wr_sdram_data = 16'hA5A5; tb_dq_en = 1'b1;

    repeat (3) @(negedge sys_clk);
    push("reset_state", e_init, 1'b1, TB_DQ);
    drain();
    check_val("reset_cke", {31'd0, sdram_cke}, 32'd1);

    sys_rst_n = 1'b1;
    wr_req = 1'b1;
    for (int i = 0; i < 100; i++) cyc("idle_no_grant", e_init, (i == 0), TB_DQ);

    init_end = 1'b1;
    cyc("idle_to_arbit", e_nop, 1'b0, '0);
    cyc("grant_wr", e_wr, 1'b0, '0);

    wr_sdram_en = 1'b1; tb_dq_en = 1'b0;
    cyc("wr_dq_drive", e_wr, 1'b1, 16'hA5A5);
    wr_sdram_en = 1'b0; tb_dq_en = 1'b1;
    cyc("wr_dq_release", e_wr, 1'b1, TB_DQ);

    rd_end = 1'b1;
    cyc("rd_end_ignored", e_wr, 1'b0, '0);
    rd_end = 1'b0;

    aref_req = 1'b1;
    cyc("aref_no_preempt", e_wr, 1'b0, '0);
    cyc("aref_no_preempt2", e_wr, 1'b0, '0);
    wr_end = 1'b1; wr_req = 1'b0;
    cyc("wr_end_nop", e_nop, 1'b0, '0);
    wr_end = 1'b0;
    cyc("aref_after_wr", e_aref, 1'b0, '0);
    aref_end = 1'b1; aref_req = 1'b0;
    cyc("aref_end_nop", e_nop, 1'b0, '0);
    aref_end = 1'b0;
    cyc("arbit_no_req", e_nop, 1'b0, '0);

    aref_req = 1'b1; wr_req = 1'b1; rd_req = 1'b1;
    cyc("prio_aref", e_aref, 1'b0, '0);
    cyc("aref_hold", e_aref, 1'b0, '0);
    aref_end = 1'b1; aref_req = 1'b0;
    cyc("nop_after_aref", e_nop, 1'b0, '0);
    aref_end = 1'b0;
    cyc("prio_wr", e_wr, 1'b0, '0);
    wr_end = 1'b1; wr_req = 1'b0;
    cyc("nop_after_wr", e_nop, 1'b0, '0);
    wr_end = 1'b0;
    cyc("grant_rd", e_rd, 1'b1, TB_DQ);
    wr_end = 1'b1;
    cyc("wr_end_ignored", e_rd, 1'b1, TB_DQ);
    wr_end = 1'b0;

    sys_rst_n = 1'b0;
    push("rst_mid_read", e_init, 1'b1, TB_DQ);
    #1;
    drain();
    cyc("rst_hold", e_init, 1'b0, '0);
    sys_rst_n = 1'b1;
    cyc("rst_rel_arbit", e_nop, 1'b0, '0);
    cyc("rst_rel_rd", e_rd, 1'b0, '0);
    rd_end = 1'b1; rd_req = 1'b0;
    cyc("rd_end_nop", e_nop, 1'b0, '0);
    rd_end = 1'b0;
    cyc("final_arbit", e_nop, 1'b0, '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
